sd_access_sched: RTL and testbench

Scheduler for the SD-card SPI port: arbitrates single-block read and write requests from two clients, sequences the `sd_read`/`sd_write` engines one transfer at a time, and owns the `SD_cs`/`SD_datain` mux. Before `init_done` it hands the bus to the init engine. It supervises each transfer with a timeout and resets a stalled engine. It sits between the application logic and the three SD engines, all clocked by `SD_clk`.

---
 rtl/sd_access_sched.sv | 144 ++++++++++++++
 tb/tb_sd_access_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_access_sched.sv
// SD SPI access scheduler: round-robin arbitration of single-block read/write
// requests, engine sequencing with timeout supervision, and SD bus ownership.
module sd_access_sched #(
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned TO_W        = 22,
  parameter int unsigned RECOVER_CYC = 16
) (
  input  logic        SD_clk,
  input  logic        reset,
  input  logic        init_done,
  input  logic        init_cs,
  input  logic        init_datain,
  input  logic        wr_req,
  input  logic [31:0] wr_sec,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [31:0] rd_sec,
  output logic        rd_ack,
  output logic [31:0] eng_sec,
  output logic        eng_write_req,
  output logic        eng_read_req,
  input  logic        eng_write_o,
  input  logic        eng_read_o,
  output logic        eng_init,
  input  logic        w_cs,
  input  logic        w_datain,
  input  logic        r_cs,
  input  logic        r_datain,
  output logic        SD_cs,
  output logic        SD_datain,
  output logic        busy,
  output logic        cur_wr,
  output logic        done,
  output logic        err
);

  localparam int unsigned RC_W = $clog2(RECOVER_CYC + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DONE, RECOVER} state_t;

  state_t            state;
  logic              last_wr;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_inc;
  logic [RC_W-1:0]   rc_cnt;
  logic              cpl_q;
  logic              cpl_in;
  logic              cpl_edge;
  logic              to_hit;
  logic              any_req;
  logic              pick_wr;

  always_comb begin
    cpl_in   = cur_wr ? eng_write_o : eng_read_o;
    cpl_edge = cpl_in & ~cpl_q;
    to_inc   = (to_cnt == '1) ? to_cnt : to_cnt + TO_W'(1);
    to_hit   = (to_inc >= TO_W'(TIMEOUT));
    any_req  = init_done & (wr_req | rd_req);
    // Lone requester wins; on contention the side not served last time wins.
    pick_wr  = wr_req & (~rd_req | ~last_wr);
  end

  // Grant outputs are loaded on the IDLE->GRANT edge so they are visible for
  // exactly the one GRANT cycle.
  always_ff @(posedge SD_clk) begin
    if (reset) begin
      state         <= IDLE;
      last_wr       <= 1'b1;
      cur_wr        <= 1'b0;
      eng_sec       <= '0;
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      eng_write_req <= 1'b0;
      eng_read_req  <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      to_cnt        <= '0;
      rc_cnt        <= '0;
      cpl_q         <= 1'b0;
    end else begin
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      eng_write_req <= 1'b0;
      eng_read_req  <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      cpl_q         <= cpl_in;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state         <= GRANT;
            wr_ack        <= pick_wr;
            rd_ack        <= ~pick_wr;
            eng_write_req <= pick_wr;
            eng_read_req  <= ~pick_wr;
            eng_sec       <= pick_wr ? wr_sec : rd_sec;
            cur_wr        <= pick_wr;
            last_wr       <= pick_wr;
          end
        end
        GRANT: begin
          to_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          to_cnt <= to_inc;
          if (!init_done) begin
            err    <= 1'b1;
            rc_cnt <= '0;
            state  <= RECOVER;
          end else if (cpl_edge) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (to_hit) begin
            err    <= 1'b1;
            rc_cnt <= '0;
            state  <= RECOVER;
          end
        end
        RECOVER: begin
          if (rc_cnt == RC_W'(RECOVER_CYC - 1)) state <= IDLE;
          else rc_cnt <= rc_cnt + RC_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    eng_init = ~reset & (state != RECOVER) & init_done;
    if (!init_done) begin
      SD_cs     = init_cs;
      SD_datain = init_datain;
    end else if (state == WAIT_DONE) begin
      SD_cs     = cur_wr ? w_cs     : r_cs;
      SD_datain = cur_wr ? w_datain : r_datain;
    end else begin
      SD_cs     = 1'b1;
      SD_datain = 1'b1;
    end
  end

endmodule

// File: tb/tb_sd_access_sched.sv
// Bench for sd_access_sched: directed scenarios plus randomized request rounds
// checked against a transaction-level scheduling model.
module tb_sd_access_sched;

  localparam int TIMEOUT = 700;
  localparam int RECOVER = 16;

  logic        SD_clk = 1'b0;
  logic        reset, init_done, init_cs, init_datain;
  logic        wr_req, rd_req;
  logic [31:0] wr_sec, rd_sec;
  logic        wr_ack, rd_ack;
  logic [31:0] eng_sec;
  logic        eng_write_req, eng_read_req, eng_write_o, eng_read_o, eng_init;
  logic        w_cs, w_datain, r_cs, r_datain;
  logic        SD_cs, SD_datain, busy, cur_wr, done, err;

  int          n_pass  = 0;
  int          n_total = 0;
  logic        m_last_wr;
  logic        got;

  sd_access_sched #(.TIMEOUT(TIMEOUT), .TO_W(22), .RECOVER_CYC(RECOVER)) dut (
    .SD_clk(SD_clk), .reset(reset), .init_done(init_done),
    .init_cs(init_cs), .init_datain(init_datain),
    .wr_req(wr_req), .wr_sec(wr_sec), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_sec(rd_sec), .rd_ack(rd_ack),
    .eng_sec(eng_sec), .eng_write_req(eng_write_req), .eng_read_req(eng_read_req),
    .eng_write_o(eng_write_o), .eng_read_o(eng_read_o), .eng_init(eng_init),
    .w_cs(w_cs), .w_datain(w_datain), .r_cs(r_cs), .r_datain(r_datain),
    .SD_cs(SD_cs), .SD_datain(SD_datain), .busy(busy), .cur_wr(cur_wr),
    .done(done), .err(err)
  );

  always #5 SD_clk = ~SD_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge SD_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @%0t: observed %b expected %b", tag, $time, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @%0t: observed %h expected %h", tag, $time, obs, exp);
  endtask

  // Called in the cycle err is expected; ends in the first IDLE cycle.
  task automatic recover_chk();
    for (int i = 1; i <= RECOVER; i++) begin
      chk1("rec_err", err, (i == 1));
      chk1("rec_done", done, 1'b0);
      chk1("rec_busy", busy, 1'b1);
      chk1("rec_eng_init", eng_init, 1'b0);
      chk1("rec_sd_cs", SD_cs, 1'b1);
      chk1("rec_sd_datain", SD_datain, 1'b1);
      tick();
    end
    chk1("post_rec_busy", busy, 1'b0);
    chk1("post_rec_eng_init", eng_init, 1'b1);
    chk1("post_rec_err", err, 1'b0);
  endtask

  // One transfer from IDLE. lat = WAIT_DONE cycle in which the engine raises
  // its completion level; lat > TIMEOUT means it never does.
  task automatic serve(input int lat, output logic got_wr);
    logic        exp_wr;
    logic [31:0] exp_sec;
    int          lim;
    exp_wr  = (wr_req && rd_req) ? ~m_last_wr : wr_req;
    exp_sec = exp_wr ? wr_sec : rd_sec;
    tick();
    got_wr = wr_ack;
    chk1("wr_ack", wr_ack, exp_wr);
    chk1("rd_ack", rd_ack, ~exp_wr);
    chk1("eng_write_req", eng_write_req, exp_wr);
    chk1("eng_read_req", eng_read_req, ~exp_wr);
    chk32("eng_sec", eng_sec, exp_sec);
    chk1("grant_cur_wr", cur_wr, exp_wr);
    chk1("grant_busy", busy, 1'b1);
    chk1("grant_done", done, 1'b0);
    m_last_wr = exp_wr;
    if (exp_wr) wr_req = 1'b0; else rd_req = 1'b0;
    tick();
    chk1("ack_one_cycle", wr_ack | rd_ack, 1'b0);
    chk1("req_one_cycle", eng_write_req | eng_read_req, 1'b0);
    lim = (lat <= TIMEOUT) ? lat : TIMEOUT;
    for (int k = 1; k <= lim; k++) begin
      chk1("wait_done", done, 1'b0);
      chk1("wait_err", err, 1'b0);
      chk1("wait_busy", busy, 1'b1);
      w_cs = 1'($urandom); w_datain = 1'($urandom);
      r_cs = 1'($urandom); r_datain = 1'($urandom);
      #1;
      chk1("mux_cs", SD_cs, exp_wr ? w_cs : r_cs);
      chk1("mux_datain", SD_datain, exp_wr ? w_datain : r_datain);
      if (k == lat) begin
        if (exp_wr) eng_write_o = 1'b1; else eng_read_o = 1'b1;
      end
      tick();
    end
    if (lat <= TIMEOUT) begin
      chk1("done_pulse", done, 1'b1);
      chk1("done_err", err, 1'b0);
      chk1("done_busy", busy, 1'b0);
      chk1("done_cur_wr", cur_wr, exp_wr);
      eng_write_o = 1'b0;
      eng_read_o  = 1'b0;
    end else begin
      chk1("timeout_done", done, 1'b0);
      recover_chk();
    end
  endtask

  initial begin
    reset = 1'b1; init_done = 1'b0; init_cs = 1'b1; init_datain = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; wr_sec = '0; rd_sec = '0;
    eng_write_o = 1'b0; eng_read_o = 1'b0;
    w_cs = 1'b1; w_datain = 1'b1; r_cs = 1'b1; r_datain = 1'b1;
    m_last_wr = 1'b1;
    repeat (3) tick();
    chk1("rst_wr_ack", wr_ack, 1'b0);
    chk1("rst_rd_ack", rd_ack, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_cur_wr", cur_wr, 1'b0);
    chk32("rst_eng_sec", eng_sec, 32'h0);
    chk1("rst_eng_init", eng_init, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);

    // Bus belongs to the init engine and requests are ignored before init_done.
    reset = 1'b0;
    wr_req = 1'b1; wr_sec = 32'hDEAD_BEEF;
    for (int i = 0; i < 8; i++) begin
      init_cs = 1'(i); init_datain = 1'($urandom);
      #1;
      chk1("init_sd_cs", SD_cs, init_cs);
      chk1("init_sd_datain", SD_datain, init_datain);
      tick();
      chk1("init_no_ack", wr_ack, 1'b0);
      chk1("init_busy", busy, 1'b0);
      chk1("init_eng_init", eng_init, 1'b0);
    end
    wr_req = 1'b0;
    init_cs = 1'b0; init_datain = 1'b0;
    init_done = 1'b1;
    tick();
    chk1("idle_eng_init", eng_init, 1'b1);
    chk1("idle_sd_cs", SD_cs, 1'b1);
    chk1("idle_sd_datain", SD_datain, 1'b1);
    chk1("idle_no_ack", wr_ack, 1'b0);

    // Single write completing after 600 cycles.
    wr_req = 1'b1; wr_sec = 32'h0000_1234;
    serve(600, got);

    // Contention: R, W, R, W.
    wr_req = 1'b1; rd_req = 1'b1; wr_sec = $urandom; rd_sec = $urandom;
    serve(5, got);  chk1("rr_first_read", got, 1'b0);
    serve(7, got);  chk1("rr_then_write", got, 1'b1);
    wr_req = 1'b1; rd_req = 1'b1; wr_sec = $urandom; rd_sec = $urandom;
    serve(3, got);  chk1("rr_read_again", got, 1'b0);
    serve(4, got);  chk1("rr_write_again", got, 1'b1);

    // Engine never completes; then completion in the very cycle the timeout hits.
    wr_req = 1'b1; wr_sec = 32'h0000_0042;
    serve(TIMEOUT + 10, got);
    rd_req = 1'b1; rd_sec = 32'hFFFF_FFFF;
    serve(TIMEOUT, got);

    // init_done dropped mid-read.
    rd_req = 1'b1; rd_sec = 32'h0BAD_F00D;
    tick();
    chk1("drop_rd_ack", rd_ack, 1'b1);
    rd_req = 1'b0; m_last_wr = 1'b0;
    repeat (4) tick();
    init_done = 1'b0; init_cs = 1'b0;
    tick();
    chk1("drop_err", err, 1'b1);
    chk1("drop_done", done, 1'b0);
    chk1("drop_eng_init", eng_init, 1'b0);
    chk1("drop_sd_cs_init", SD_cs, 1'b0);
    init_done = 1'b1;
    #1;
    recover_chk();

    // Reset in the middle of a read.
    rd_req = 1'b1; rd_sec = 32'h1357_9BDF;
    tick();
    chk1("mid_rd_ack", rd_ack, 1'b1);
    rd_req = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk1("mid_rst_err", err, 1'b0);
    chk1("mid_rst_cur_wr", cur_wr, 1'b0);
    chk32("mid_rst_eng_sec", eng_sec, 32'h0);
    chk1("mid_rst_eng_init", eng_init, 1'b0);
    chk1("mid_rst_acks", wr_ack | rd_ack | eng_write_req | eng_read_req, 1'b0);
    reset = 1'b0; m_last_wr = 1'b1;
    eng_read_o = 1'b1;
    tick();
    chk1("post_rst_done", done, 1'b0);
    chk1("post_rst_err", err, 1'b0);
    eng_read_o = 1'b0;
    tick();
    wr_req = 1'b1; rd_req = 1'b1; wr_sec = $urandom; rd_sec = $urandom;
    serve(6, got);  chk1("post_rst_read_first", got, 1'b0);
    serve(2, got);

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      int idle_n, pat, lat;
      idle_n = int'($urandom_range(0, 3));
      for (int i = 0; i < idle_n; i++) begin
        tick();
        chk1("rand_idle_busy", busy, 1'b0);
      end
      pat = int'($urandom_range(1, 3));
      wr_req = (pat != 2); rd_req = (pat != 1);
      wr_sec = $urandom; rd_sec = $urandom;
      lat = ($urandom_range(0, 15) == 0) ? TIMEOUT + 1 : int'($urandom_range(1, 40));
      serve(lat, got);
      if (pat == 3) serve(int'($urandom_range(1, 40)), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
